// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM state
// encodings and the priority-source codes that select the output pattern.
package pipeline_stall_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MEM_WAIT   = 2'd1,
    ST_HALT_DRAIN = 2'd2,
    ST_HALTED     = 2'd3
  } pipe_state_e;

  // Which condition won arbitration this cycle; the output pattern is a
  // pure function of this code.
  typedef enum logic [3:0] {
    SRC_RUN      = 4'd0,  // normal advance
    SRC_RESET    = 4'd1,  // reset held: everything quiet
    SRC_FREEZE   = 4'd2,  // D-mem access outstanding
    SRC_FLUSH    = 4'd3,  // EX mispredict
    SRC_LOAD_USE = 4'd4,  // load-use bubble
    SRC_HALT     = 4'd5,  // halting ecall seen in ID
    SRC_IMEM     = 4'd6,  // fetch data not valid
    SRC_DRAIN    = 4'd7,  // retiring instructions ahead of halt
    SRC_HALTED   = 4'd8   // pipeline parked
  } stall_src_e;

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating event counter: increments on inc, sticks at all-ones.
module pipeline_stall_controller_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: hold at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) count_d = count_q + 1'b1;
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Optional feature macro: STALL_PERF_CNT_EN builds the three saturating
// stall-cycle counters; without it the count ports are tied to zero.
// Handshake note: this block has no valid/ready pairs of its own. dmem_req
// with dmem_ready low means the MEM access is outstanding and the whole
// pipeline freezes; the cycle dmem_ready rises is a normal working cycle.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int HALT_DRAIN_CYCLES = 3,
  parameter int CNT_W             = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic             IF_ID_use_rs1,
  input  logic             IF_ID_use_rs2,
  input  logic [4:0]       ID_EX_rd,
  input  logic             ID_EX_mem_read,
  input  logic             EX_mispredict,
  input  logic             ID_halt,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             IF_ID_write,
  output logic             ID_EX_write,
  output logic             EX_MEM_write,
  output logic             MEM_WB_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_flush,
  output logic             is_stall,
  output logic             halted,
  output logic [CNT_W-1:0] cnt_load_use,
  output logic [CNT_W-1:0] cnt_mem_wait,
  output logic [CNT_W-1:0] cnt_flush,
  output logic [1:0]       dbg_state
);

  localparam int DRAIN_W = $clog2(HALT_DRAIN_CYCLES + 1);

  pipe_state_e        state_q, state_d;
  pipe_state_e        ret_q, ret_d;      // state to resume after MEM_WAIT
  logic [DRAIN_W-1:0] drain_q, drain_d;
  pipe_state_e        eff_state;
  stall_src_e         src;
  logic               freeze;
  logic               load_use;

  // State, return-state and drain-counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      ret_q   <= ST_RUN;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      drain_q <= drain_d;
    end
  end

  // Arbitration and next state. MEM_WAIT is evaluated as the state it
  // interrupted, so the cycle the access completes is not lost.
  always_comb begin
    freeze    = dmem_req & ~dmem_ready;
    eff_state = (state_q == ST_MEM_WAIT) ? ret_q : state_q;
    load_use  = ID_EX_mem_read & (ID_EX_rd != 5'd0) &
                ((IF_ID_use_rs1 & (IF_ID_rs1 == ID_EX_rd)) |
                 (IF_ID_use_rs2 & (IF_ID_rs2 == ID_EX_rd)));
    src     = SRC_RUN;
    state_d = state_q;
    ret_d   = ret_q;
    drain_d = drain_q;
    if (reset) begin
      src     = SRC_RESET;
      state_d = ST_RUN;
      ret_d   = ST_RUN;
      drain_d = '0;
    end else if (eff_state == ST_HALTED) begin
      src     = SRC_HALTED;
    end else if (freeze) begin
      src     = SRC_FREEZE;
      state_d = ST_MEM_WAIT;
      ret_d   = eff_state;
    end else if (eff_state == ST_HALT_DRAIN) begin
      src     = SRC_DRAIN;
      drain_d = drain_q - 1'b1;
      state_d = (drain_q <= DRAIN_W'(1)) ? ST_HALTED : ST_HALT_DRAIN;
    end else begin
      state_d = ST_RUN;
      if (EX_mispredict)   src = SRC_FLUSH;
      else if (load_use)   src = SRC_LOAD_USE;
      else if (ID_halt) begin
        src     = SRC_HALT;
        state_d = ST_HALT_DRAIN;
        drain_d = DRAIN_W'(HALT_DRAIN_CYCLES);
      end
      else if (!imem_ready) src = SRC_IMEM;
      else                  src = SRC_RUN;
    end
  end

  // Stage enables and flushes decoded from the winning source.
  always_comb begin
    pc_write     = 1'b0;
    IF_ID_write  = 1'b0;
    ID_EX_write  = 1'b0;
    EX_MEM_write = 1'b0;
    MEM_WB_write = 1'b0;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    halted       = 1'b0;
    case (src)
      SRC_RUN: begin
        {pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write} = 5'b11111;
      end
      SRC_FLUSH: begin
        {pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write} = 5'b11111;
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
      end
      SRC_LOAD_USE: begin
        {ID_EX_write, EX_MEM_write, MEM_WB_write} = 3'b111;
        ID_EX_flush = 1'b1;
      end
      SRC_HALT, SRC_IMEM, SRC_DRAIN: begin
        {IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write} = 4'b1111;
        IF_ID_flush = 1'b1;
      end
      SRC_HALTED: halted = 1'b1;
      default: ;
    endcase
    is_stall = ~pc_write & ~halted & ~reset;
  end

  assign dbg_state = state_q;

`ifdef STALL_PERF_CNT_EN
  logic inc_load_use, inc_mem_wait, inc_flush;
  assign inc_load_use = (src == SRC_LOAD_USE);
  assign inc_mem_wait = (src == SRC_FREEZE);
  assign inc_flush    = (src == SRC_FLUSH);

  pipeline_stall_controller_sat_counter #(.CNT_W(CNT_W)) u_cnt_load_use (
    .clk(clk), .reset(reset), .inc(inc_load_use), .count(cnt_load_use));
  pipeline_stall_controller_sat_counter #(.CNT_W(CNT_W)) u_cnt_mem_wait (
    .clk(clk), .reset(reset), .inc(inc_mem_wait), .count(cnt_mem_wait));
  pipeline_stall_controller_sat_counter #(.CNT_W(CNT_W)) u_cnt_flush (
    .clk(clk), .reset(reset), .inc(inc_flush), .count(cnt_flush));
`else
  assign cnt_load_use = '0;
  assign cnt_mem_wait = '0;
  assign cnt_flush    = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Testbench for pipeline_stall_controller. Expected per-cycle output
// patterns are pushed to a queue as each cycle's stimulus is driven and
// popped at the following negedge against the DUT outputs.
module tb_pipeline_stall_controller;
  import pipeline_stall_controller_pkg::*;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  // Output vector: {pc,IF_ID,ID_EX,EX_MEM,MEM_WB writes, IF_ID_flush, ID_EX_flush, is_stall, halted}
  localparam logic [8:0] O_ZERO   = 9'b00000_00_0_0;
  localparam logic [8:0] O_ALL    = 9'b11111_00_0_0;
  localparam logic [8:0] O_FREEZE = 9'b00000_00_1_0;
  localparam logic [8:0] O_LU     = 9'b00111_01_1_0;
  localparam logic [8:0] O_FLUSH  = 9'b11111_11_0_0;
  localparam logic [8:0] O_IFL    = 9'b01111_10_1_0;
  localparam logic [8:0] O_HALTED = 9'b00000_00_0_1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd;
  logic IF_ID_use_rs1, IF_ID_use_rs2, ID_EX_mem_read, EX_mispredict, ID_halt;
  logic imem_ready, dmem_req, dmem_ready;
  logic pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write;
  logic IF_ID_flush, ID_EX_flush, is_stall, halted;
  logic [CNT_W-1:0] cnt_load_use, cnt_mem_wait, cnt_flush;
  logic [1:0] dbg_state;

  pipeline_stall_controller #(.HALT_DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
    .IF_ID_use_rs1(IF_ID_use_rs1), .IF_ID_use_rs2(IF_ID_use_rs2),
    .ID_EX_rd(ID_EX_rd), .ID_EX_mem_read(ID_EX_mem_read),
    .EX_mispredict(EX_mispredict), .ID_halt(ID_halt),
    .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .IF_ID_write(IF_ID_write), .ID_EX_write(ID_EX_write),
    .EX_MEM_write(EX_MEM_write), .MEM_WB_write(MEM_WB_write),
    .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
    .is_stall(is_stall), .halted(halted),
    .cnt_load_use(cnt_load_use), .cnt_mem_wait(cnt_mem_wait), .cnt_flush(cnt_flush),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int m_lu = 0, m_mw = 0, m_fl = 0;   // reference counter model

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic logic [31:0] exp_cnt(input int v);
`ifdef STALL_PERF_CNT_EN
    return 32'(v);
`else
    return 32'(v & 0);
`endif
  endfunction

  task automatic check_counters(input string tag);
    check({tag, "_cnt_lu"}, 32'(cnt_load_use), exp_cnt(m_lu));
    check({tag, "_cnt_mw"}, 32'(cnt_mem_wait), exp_cnt(m_mw));
    check({tag, "_cnt_fl"}, 32'(cnt_flush),    exp_cnt(m_fl));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    reset = 1'b0;
    IF_ID_rs1 = 5'd0; IF_ID_rs2 = 5'd0; ID_EX_rd = 5'd0;
    IF_ID_use_rs1 = 1'b0; IF_ID_use_rs2 = 1'b0; ID_EX_mem_read = 1'b0;
    EX_mispredict = 1'b0; ID_halt = 1'b0;
    imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ID_EX_mem_read = 1'b1; ID_EX_rd = rd;
    IF_ID_rs1 = rd; IF_ID_use_rs1 = 1'b1;
  endtask

  // One clock cycle with the inputs currently driven; exp is the required
  // output pattern for that cycle.
  task automatic step(input string tag, input logic [8:0] exp);
    logic [8:0] got;
    exp_q.push_back(exp);
    @(negedge clk);
    got = {pc_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write,
           IF_ID_flush, ID_EX_flush, is_stall, halted};
    check(tag, 32'(got), 32'(exp_q.pop_front()));
    if (exp == O_ZERO) begin m_lu = 0; m_mw = 0; m_fl = 0; end
    else if (exp == O_LU)     m_lu = sat_inc(m_lu);
    else if (exp == O_FREEZE) m_mw = sat_inc(m_mw);
    else if (exp == O_FLUSH)  m_fl = sat_inc(m_fl);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] rd;
    idle_inputs();
    reset = 1'b1;
    step("reset0", O_ZERO);
    step("reset1", O_ZERO);
    check("reset_state", 32'(dbg_state), 32'(ST_RUN));
    check_counters("reset");
    idle_inputs();
    step("run_idle", O_ALL);

    // load-use on rs1, one bubble then advance
    set_load_use(5'd5);
    step("lu_rs1", O_LU);
    idle_inputs();
    step("lu_after", O_ALL);
    // load-use on rs2 with random rd
    rd = 5'($urandom_range(1, 31));
    ID_EX_mem_read = 1'b1; ID_EX_rd = rd; IF_ID_rs2 = rd; IF_ID_use_rs2 = 1'b1;
    step("lu_rs2", O_LU);
    // same register but operand not read: no hazard
    IF_ID_use_rs2 = 1'b0;
    step("lu_nouse", O_ALL);
    // rd = x0 never a hazard
    idle_inputs();
    set_load_use(5'd0);
    step("lu_x0", O_ALL);
    // not a load: no hazard
    set_load_use(5'd9); ID_EX_mem_read = 1'b0;
    step("lu_noload", O_ALL);
    check_counters("after_lu");

    // mispredict beats load-use and halt
    idle_inputs();
    set_load_use(5'd5); EX_mispredict = 1'b1; ID_halt = 1'b1;
    step("mispredict", O_FLUSH);
    check("mp_state", 32'(dbg_state), 32'(ST_RUN));
    check_counters("after_mp");

    // fetch not ready
    idle_inputs(); imem_ready = 1'b0;
    step("imem_wait", O_IFL);

    // 4 freeze cycles then completion cycle advances
    idle_inputs(); dmem_req = 1'b1;
    for (int i = 0; i < 4; i++) step("freeze4", O_FREEZE);
    check("mw_state", 32'(dbg_state), 32'(ST_MEM_WAIT));
    dmem_ready = 1'b1;
    step("freeze_exit", O_ALL);
    check_counters("after_freeze");
    // completion cycle is a real RUN cycle: a load-use there still stalls
    dmem_ready = 1'b0;
    step("freeze_b", O_FREEZE);
    dmem_ready = 1'b1; set_load_use(5'd12);
    step("freeze_exit_lu", O_LU);

    // halt with one freeze inside the drain
    idle_inputs(); ID_halt = 1'b1;
    step("halt", O_IFL);
    check("drain_state", 32'(dbg_state), 32'(ST_HALT_DRAIN));
    idle_inputs();
    step("drain1", O_IFL);
    dmem_req = 1'b1;
    step("drain_frz", O_FREEZE);
    dmem_ready = 1'b1;
    step("drain2", O_IFL);
    idle_inputs();
    step("drain3", O_IFL);
    step("halted0", O_HALTED);
    dmem_req = 1'b1; EX_mispredict = 1'b1;
    step("halted_sticky", O_HALTED);
    check("halted_state", 32'(dbg_state), 32'(ST_HALTED));

    // reset in HALTED
    idle_inputs(); reset = 1'b1;
    step("rst_halted", O_ZERO);
    idle_inputs();
    step("run_after_halt", O_ALL);
    check_counters("after_rst_halt");

    // reset mid-MEM_WAIT
    dmem_req = 1'b1;
    step("mw_a", O_FREEZE);
    step("mw_b", O_FREEZE);
    reset = 1'b1;
    step("rst_mw", O_ZERO);
    idle_inputs();
    step("run_after_mw", O_ALL);
    check("rst_mw_state", 32'(dbg_state), 32'(ST_RUN));

    // reset mid-drain
    ID_halt = 1'b1;
    step("halt2", O_IFL);
    idle_inputs();
    step("drain_b", O_IFL);
    reset = 1'b1;
    step("rst_drain", O_ZERO);
    idle_inputs();
    step("run_after_drain", O_ALL);
    step("run_after_drain2", O_ALL);

    // drive every counter past its ceiling
    for (int i = 0; i < CMAX + 3; i++) begin
      idle_inputs(); set_load_use(5'($urandom_range(1, 31)));
      step("sat_lu", O_LU);
      idle_inputs(); EX_mispredict = 1'b1;
      step("sat_fl", O_FLUSH);
      idle_inputs(); dmem_req = 1'b1;
      step("sat_mw", O_FREEZE);
      dmem_ready = 1'b1;
      step("sat_mw_exit", O_ALL);
    end
    check_counters("saturated");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
